// File: rtl/layer_compositor_if.sv
// Pixel/colour/collision bus between the object managers, the compositor and vga_sync.
// The master side drives pixels, colours and group masks; the slave (compositor) drives RGB and hits.
interface layer_compositor_if #(
   parameter int unsigned N_LAYERS = 16,
   parameter int unsigned COLOR_W  = 10
);
   logic [9:0]                    iPx;
   logic [9:0]                    iPy;
   logic                          iActive;
   logic [N_LAYERS-1:0]           iPixel;
   logic [N_LAYERS*3*COLOR_W-1:0] iLayerColor;
   logic [N_LAYERS-1:0]           iGroupA;
   logic [N_LAYERS-1:0]           iGroupB;
   logic [COLOR_W-1:0]            oR;
   logic [COLOR_W-1:0]            oG;
   logic [COLOR_W-1:0]            oB;
   logic [9:0]                    oPx;
   logic [9:0]                    oPy;
   logic [N_LAYERS-1:0]           oHitLayer;
   logic                          oHitValid;
   logic [15:0]                   oHitCount;

   modport master (
      output iPx, iPy, iActive, iPixel, iLayerColor, iGroupA, iGroupB,
      input  oR, oG, oB, oPx, oPy, oHitLayer, oHitValid, oHitCount
   );

   modport slave (
      input  iPx, iPy, iActive, iPixel, iLayerColor, iGroupA, iGroupB,
      output oR, oG, oB, oPx, oPy, oHitLayer, oHitValid, oHitCount
   );
endinterface

// File: rtl/layer_compositor.sv
// Priority compositor of N_LAYERS sprite pixel streams with per-frame A/B group collision flags.
// Define LAYER_COMPOSITOR_HITCOUNT_EN to build the saturating colliding-pixel counter (oHitCount).
module layer_compositor #(
   parameter int unsigned           N_LAYERS = 16,
   parameter int unsigned           COLOR_W  = 10,
   parameter logic [3*COLOR_W-1:0]  BG_COLOR = '0
) (
   input logic               iCLK,
   input logic               iRST_N,
   layer_compositor_if.slave bus
);
   localparam int unsigned PIX_W = 3 * COLOR_W;
   localparam logic [N_LAYERS-1:0] ONE = {{(N_LAYERS-1){1'b0}}, 1'b1};

   logic [N_LAYERS-1:0] r_s1_pix;
   logic [9:0]          r_s1_px;
   logic [9:0]          r_s1_py;
   logic                r_s1_active;
   logic                r_prev_zero;

   logic [PIX_W-1:0]    r_rgb;
   logic [9:0]          r_px;
   logic [9:0]          r_py;

   logic [N_LAYERS-1:0] r_mask_a;
   logic [N_LAYERS-1:0] r_mask_b;
   logic [N_LAYERS-1:0] r_acc;
   logic                r_primed;
   logic [N_LAYERS-1:0] r_hit_layer;
   logic                r_hit_valid;

   logic [PIX_W-1:0]    w_color;
   logic                w_s1_zero;
   logic                w_frame_evt;
   logic [N_LAYERS-1:0] w_pa;
   logic [N_LAYERS-1:0] w_pb;
   logic                w_pa_single;
   logic                w_collide;
   logic [N_LAYERS-1:0] w_coll_bits;

   // Scan from the top so the lowest-index set layer is the one that sticks.
   always_comb begin
      w_color = BG_COLOR;
      for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
         if (r_s1_pix[i]) begin
            w_color = bus.iLayerColor[i*PIX_W +: PIX_W];
         end
      end
      if (!r_s1_active) begin
         w_color = '0;
      end
   end

   assign w_s1_zero   = (r_s1_px == 10'd0) && (r_s1_py == 10'd0);
   assign w_frame_evt = w_s1_zero && !r_prev_zero;

   // A collision needs a distinct A/B layer pair: one lone layer present in both groups is not one.
   assign w_pa        = r_s1_pix & r_mask_a;
   assign w_pb        = r_s1_pix & r_mask_b;
   assign w_pa_single = ((w_pa & (w_pa - ONE)) == '0);
   assign w_collide   = r_s1_active && (|w_pa) && (|w_pb) && !((w_pa == w_pb) && w_pa_single);
   assign w_coll_bits = r_s1_pix & (r_mask_a | r_mask_b);

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_s1_pix    <= '0;
         r_s1_px     <= '0;
         r_s1_py     <= '0;
         r_s1_active <= 1'b0;
         r_prev_zero <= 1'b1;
         r_rgb       <= '0;
         r_px        <= '0;
         r_py        <= '0;
      end else begin
         r_s1_pix    <= bus.iPixel;
         r_s1_px     <= bus.iPx;
         r_s1_py     <= bus.iPy;
         r_s1_active <= bus.iActive;
         r_prev_zero <= w_s1_zero;
         r_rgb       <= w_color;
         r_px        <= r_s1_px;
         r_py        <= r_s1_py;
      end
   end

   // The boundary pixel's own collision seeds the new frame rather than the published one.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_mask_a    <= '0;
         r_mask_b    <= '0;
         r_acc       <= '0;
         r_primed    <= 1'b0;
         r_hit_layer <= '0;
         r_hit_valid <= 1'b0;
      end else begin
         r_hit_valid <= 1'b0;
         if (w_frame_evt) begin
            if (r_primed) begin
               r_hit_layer <= r_acc;
               r_hit_valid <= 1'b1;
            end
            r_acc    <= w_collide ? w_coll_bits : '0;
            r_mask_a <= bus.iGroupA;
            r_mask_b <= bus.iGroupB;
            r_primed <= 1'b1;
         end else if (w_collide) begin
            r_acc <= r_acc | w_coll_bits;
         end
      end
   end

`ifdef LAYER_COMPOSITOR_HITCOUNT_EN
   logic [15:0] r_cnt;
   logic [15:0] r_hit_count;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         r_cnt       <= '0;
         r_hit_count <= '0;
      end else if (w_frame_evt) begin
         if (r_primed) begin
            r_hit_count <= r_cnt;
         end
         r_cnt <= {15'd0, w_collide};
      end else if (w_collide && (r_cnt != 16'hFFFF)) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   assign bus.oHitCount = r_hit_count;
`else
   assign bus.oHitCount = 16'd0;
`endif

   assign bus.oR        = r_rgb[3*COLOR_W-1:2*COLOR_W];
   assign bus.oG        = r_rgb[2*COLOR_W-1:COLOR_W];
   assign bus.oB        = r_rgb[COLOR_W-1:0];
   assign bus.oPx       = r_px;
   assign bus.oPy       = r_py;
   assign bus.oHitLayer = r_hit_layer;
   assign bus.oHitValid = r_hit_valid;
endmodule

// File: tb/tb_layer_compositor.sv
// Bench for layer_compositor: colour table, hand-built frame sequences and random frames
// checked every cycle against a rule-level model of compositing and per-frame collisions.
module tb_layer_compositor;
   localparam int unsigned NL = 16;
   localparam int unsigned CW = 10;
   localparam int unsigned PW = 3 * CW;
   localparam logic [PW-1:0] BG = 30'h0ABCDEF1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   layer_compositor_if #(.N_LAYERS(NL), .COLOR_W(CW)) bus ();
   logic [NL*PW-1:0] lc;
   assign bus.iLayerColor = lc;

   layer_compositor #(.N_LAYERS(NL), .COLOR_W(CW), .BG_COLOR(BG)) dut (
      .iCLK  (clk),
      .iRST_N(rst_n),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // Model state: what the frame rules say has happened so far.
   logic [9:0]    m_s1_px, m_s1_py;
   logic          m_s1_act;
   logic [NL-1:0] m_s1_pix;
   bit            m_prev_zero;
   logic [NL-1:0] m_ma, m_mb, m_acc;
   int            m_cnt;
   bit            m_primed;
   logic [PW-1:0] e_rgb;
   logic [9:0]    e_px, e_py;
   logic [NL-1:0] e_hit;
   logic          e_valid;
   int            e_cnt;

   function automatic logic [PW-1:0] compose(logic act, logic [NL-1:0] pix);
      if (!act) return '0;
      for (int i = 0; i < int'(NL); i++) if (pix[i]) return lc[i*PW +: PW];
      return BG;
   endfunction

   function automatic bit pair_hit(logic [NL-1:0] pix, logic [NL-1:0] ma, logic [NL-1:0] mb);
      for (int a = 0; a < int'(NL); a++)
         for (int b = 0; b < int'(NL); b++)
            if (a != b && pix[a] && pix[b] && ma[a] && mb[b]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int cnt_seen(int c);
`ifdef LAYER_COMPOSITOR_HITCOUNT_EN
      return c;
`else
      return 0;
`endif
   endfunction

   task automatic model_reset();
      m_s1_px = '0; m_s1_py = '0; m_s1_act = 1'b0; m_s1_pix = '0;
      m_prev_zero = 1'b1; m_ma = '0; m_mb = '0; m_acc = '0; m_cnt = 0; m_primed = 1'b0;
      e_rgb = '0; e_px = '0; e_py = '0; e_hit = '0; e_valid = 1'b0; e_cnt = 0;
   endtask

   // Advance the model across one clock edge using the inputs presented before it.
   task automatic model_edge();
      bit zero, evt, hit;
      logic [NL-1:0] bits;
      e_rgb = compose(m_s1_act, m_s1_pix);
      e_px  = m_s1_px;
      e_py  = m_s1_py;
      zero  = (m_s1_px == 10'd0) && (m_s1_py == 10'd0);
      evt   = zero && !m_prev_zero;
      hit   = m_s1_act && pair_hit(m_s1_pix, m_ma, m_mb);
      bits  = m_s1_pix & (m_ma | m_mb);
      e_valid = 1'b0;
      if (evt) begin
         if (m_primed) begin
            e_valid = 1'b1;
            e_hit   = m_acc;
            e_cnt   = m_cnt;
         end
         m_acc = hit ? bits : '0;
         m_cnt = hit ? 1 : 0;
         m_ma = bus.iGroupA;
         m_mb = bus.iGroupB;
         m_primed = 1'b1;
      end else if (hit) begin
         m_acc = m_acc | bits;
         if (m_cnt < 65535) m_cnt++;
      end
      m_prev_zero = zero;
      m_s1_px = bus.iPx; m_s1_py = bus.iPy; m_s1_act = bus.iActive; m_s1_pix = bus.iPixel;
   endtask

   task automatic check_outputs(string tag);
      n_vec++;
      if ({bus.oR, bus.oG, bus.oB} !== e_rgb || bus.oPx !== e_px || bus.oPy !== e_py ||
          bus.oHitLayer !== e_hit || bus.oHitValid !== e_valid ||
          bus.oHitCount !== 16'(cnt_seen(e_cnt))) begin
         n_err++;
         $display("FAIL %s t=%0t got rgb=%h px=%0d py=%0d hit=%h v=%b cnt=%0d want rgb=%h px=%0d py=%0d hit=%h v=%b cnt=%0d",
                  tag, $time, {bus.oR, bus.oG, bus.oB}, bus.oPx, bus.oPy, bus.oHitLayer,
                  bus.oHitValid, bus.oHitCount, e_rgb, e_px, e_py, e_hit, e_valid,
                  cnt_seen(e_cnt));
      end
   endtask

   task automatic expect_val(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      check_outputs("cycle");
   endtask

   task automatic pixel(int px, int py, bit act, logic [NL-1:0] pix);
      bus.iPx = 10'(px);
      bus.iPy = 10'(py);
      bus.iActive = act;
      bus.iPixel = pix;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      model_reset();
      check_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic          act;
      logic [NL-1:0] pix;
      logic [PW-1:0] exp;
   } vec_t;
   vec_t tbl[8];

   initial begin
      logic [NL-1:0] pix;
      int len;
      for (int i = 0; i < int'(NL); i++) lc[i*PW +: PW] = 30'(32'h0101_0101 * i + 32'h55);
      lc[0*PW +: PW]  = 30'h12345678;
      lc[2*PW +: PW]  = 30'h3FF00000;
      lc[5*PW +: PW]  = 30'h000FFC00;
      lc[15*PW +: PW] = 30'h00000155;
      tbl[0] = '{1'b1, 16'h0000, BG};
      tbl[1] = '{1'b1, 16'h0024, 30'h3FF00000};
      tbl[2] = '{1'b0, 16'h0024, 30'h00000000};
      tbl[3] = '{1'b1, 16'h0020, 30'h000FFC00};
      tbl[4] = '{1'b1, 16'h8000, 30'h00000155};
      tbl[5] = '{1'b1, 16'hFFFF, 30'h12345678};
      tbl[6] = '{1'b0, 16'h0000, 30'h00000000};
      tbl[7] = '{1'b1, 16'h8020, 30'h000FFC00};

      bus.iPx = '0; bus.iPy = '0; bus.iActive = 1'b0; bus.iPixel = '0;
      bus.iGroupA = '0; bus.iGroupB = '0;
      do_reset();

      // Compositing table: each vector must appear exactly two cycles after it is applied.
      for (int i = 0; i < 8; i++) begin
         pixel(100 + i, 7, tbl[i].act, tbl[i].pix);
         pixel(300, 9, 1'b1, 16'h0000);
         expect_val("rgb_tbl", 32'({bus.oR, bus.oG, bus.oB}), 32'(tbl[i].exp));
         expect_val("px_tbl", 32'(bus.oPx), 32'(100 + i));
         expect_val("hit_idle", 32'({bus.oHitValid, bus.oHitLayer}), 32'd0);
      end

      // Collision frame after priming.
      do_reset();
      bus.iGroupA = 16'h0001; bus.iGroupB = 16'h7FE0;
      pixel(9, 9, 1'b1, 16'h0000);
      pixel(0, 0, 1'b1, 16'h0021);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("prime_no_valid", 32'(bus.oHitValid), 32'd0);
      for (int k = 2; k < 5; k++) pixel(k, 0, 1'b1, 16'h0021);
      pixel(5, 0, 1'b1, 16'h0001);
      pixel(6, 0, 1'b1, 16'h0020);
      pixel(7, 0, 1'b0, 16'h0021);
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("pub_valid", 32'(bus.oHitValid), 32'd1);
      expect_val("pub_layer", 32'(bus.oHitLayer), 32'h0021);
      expect_val("pub_count", 32'(bus.oHitCount), 32'(cnt_seen(3)));
      pixel(2, 0, 1'b1, 16'h0000);
      expect_val("valid_one_cycle", 32'(bus.oHitValid), 32'd0);
      expect_val("layer_held", 32'(bus.oHitLayer), 32'h0021);

      // No overlap, ending with a collision on the boundary pixel itself.
      pixel(3, 0, 1'b1, 16'h0001);
      pixel(4, 0, 1'b1, 16'h0040);
      pixel(0, 0, 1'b1, 16'h0021);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("no_overlap", 32'({bus.oHitValid, bus.oHitLayer}), 32'h10000);
      pixel(2, 0, 1'b1, 16'h0000);
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("boundary_pixel", 32'({bus.oHitValid, bus.oHitLayer}), 32'h10021);
      expect_val("boundary_cnt", 32'(bus.oHitCount), 32'(cnt_seen(1)));

      // Mid-frame mask changes wait for the next boundary.
      pixel(2, 0, 1'b1, 16'h0021);
      bus.iGroupB = 16'h0000;
      pixel(3, 0, 1'b1, 16'h0021);
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("old_mask_used", 32'(bus.oHitLayer), 32'h0021);
      pixel(2, 0, 1'b1, 16'h0021);
      bus.iGroupB = 16'h7FE0;
      pixel(3, 0, 1'b1, 16'h0021);
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("new_mask_used", 32'({bus.oHitValid, bus.oHitLayer}), 32'h10000);

      // A lone layer in both groups never collides; a second qualifying layer does.
      bus.iGroupA = 16'h0001; bus.iGroupB = 16'h0001;
      pixel(2, 0, 1'b1, 16'h0000);
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      pixel(2, 0, 1'b1, 16'h0001);
      pixel(3, 0, 1'b1, 16'h0001);
      bus.iGroupB = 16'h0003;
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("same_layer", 32'({bus.oHitValid, bus.oHitLayer}), 32'h10000);
      pixel(2, 0, 1'b1, 16'h0003);
      pixel(3, 0, 1'b1, 16'h0001);
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("second_layer", 32'(bus.oHitLayer), 32'h0003);

      // Reset mid-frame: first boundary only primes, second reports the full frame.
      bus.iGroupB = 16'h7FE0;
      pixel(2, 0, 1'b1, 16'h0021);
      do_reset();
      pixel(4, 4, 1'b1, 16'h0021);
      pixel(5, 4, 1'b1, 16'h0021);
      pixel(0, 0, 1'b1, 16'h0021);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("rst_prime", 32'({bus.oHitValid, bus.oHitLayer}), 32'd0);
      pixel(2, 0, 1'b1, 16'h0021);
      pixel(3, 0, 1'b1, 16'h0021);
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("rst_report", 32'({bus.oHitValid, bus.oHitLayer}), 32'h10021);
      expect_val("rst_count", 32'(bus.oHitCount), 32'(cnt_seen(2)));

      // Random short frames, random masks, occasional repeated (0,0) and mid-frame resets.
      for (int f = 0; f < 150; f++) begin
         len = int'($urandom_range(2, 40));
         for (int k = 0; k < len; k++) begin
            if ($urandom_range(0, 15) == 0) begin
               bus.iGroupA = 16'($urandom) & 16'($urandom);
               bus.iGroupB = 16'($urandom) & 16'($urandom);
            end
            pix = 16'($urandom) & 16'($urandom) & 16'($urandom);
            pixel(k % 8, k / 8, ($urandom_range(0, 4) != 0), pix);
            if (k == 0 && $urandom_range(0, 7) == 0) pixel(0, 0, 1'b1, pix);
            if (k == len / 2 && $urandom_range(0, 39) == 0) do_reset();
         end
      end

`ifdef LAYER_COMPOSITOR_HITCOUNT_EN
      // Saturation: far more colliding pixels than the counter can hold.
      bus.iGroupA = 16'h0001; bus.iGroupB = 16'h0002;
      pixel(1, 0, 1'b1, 16'h0000);
      pixel(0, 0, 1'b1, 16'h0000);
      for (int k = 1; k <= 70000; k++) pixel(k % 1000, k / 1000, 1'b1, 16'h0003);
      pixel(0, 0, 1'b1, 16'h0000);
      pixel(1, 0, 1'b1, 16'h0000);
      expect_val("saturate", 32'(bus.oHitCount), 32'h0000FFFF);
`else
      expect_val("count_absent", 32'(bus.oHitCount), 32'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised successor to the game top-level's one-bit OR of object pixels: merges N_LAYERS sprite pixel streams (ship, bullets, rocks, ...) into a registered RGB stream with per-layer colour and fixed priority.
- Adds per-frame collision detection between two programmable layer groups, with hit flags published once per frame to the 60 Hz game logic.
- Sits between the object managers and vga_sync; runs on the VGA control clock.

Parameters:
- N_LAYERS, 16, number of input pixel layers (2..32).
- COLOR_W, 10, bits per colour channel.
- BG_COLOR, 0, background {R,G,B} value, 3*COLOR_W bits.

Ports:
- iCLK  input  1  VGA control clock.
- iRST_N  input  1  asynchronous active-low reset.
- iPx  input  10  current pixel X from vga_sync.
- iPy  input  10  current pixel Y from vga_sync.
- iActive  input  1  high when (iPx, iPy) is in the visible area.
- iPixel  input  N_LAYERS  per-layer pixel-on bits; bit 0 is highest priority.
- iLayerColor  input  N_LAYERS*3*COLOR_W  layer i colour {R,G,B} at bits [(i+1)*3*COLOR_W-1 : i*3*COLOR_W].
- iGroupA  input  N_LAYERS  collision group A mask.
- iGroupB  input  N_LAYERS  collision group B mask.
- oR, oG, oB  output  COLOR_W each  composited colour.
- oPx, oPy  output  10 each  coordinates aligned with oR/oG/oB.
- oHitLayer  output  N_LAYERS  layers involved in a collision during the last completed frame.
- oHitValid  output  1  one-cycle pulse when oHitLayer updates.
- oHitCount  output  16  colliding-pixel count of the last frame (feature-gated).

Behaviour:
- Reset (async, iRST_N low) clears:
  - all outputs to 0, pipeline registers, collision accumulator, count accumulator;
  - latched group masks (no collision possible before the first frame boundary);
  - the primed flag.
- Pipeline, latency 2 cycles from iPx/iPy/iPixel/iActive to oR/oG/oB/oPx/oPy:
  - Stage 1 registers iPixel, coords and iActive.
  - Stage 2 registers the composited colour and coords.
- Compositing:
  - Colour is that of the lowest-index set bit of (stage-1 pixel).
  - No bit set: BG_COLOR.
  - Stage-1 active low: output colour forced to 0 regardless of pixels.
- Frame boundary:
  - Event fires when stage-1 coords == (0,0) and the previous stage-1 coords != (0,0); one event per frame even though (0,0) persists for one pixel.
  - On the event, iGroupA/iGroupB are sampled into mask registers held for the whole frame; mid-frame mask changes are ignored.
- Collision, evaluated on stage-1 data only when active:
  - hitA = |(pix & maskA), hitB = |(pix & maskB).
  - If hitA && hitB: accumulator |= pix & (maskA | maskB), and count += 1, saturating at 16'hFFFF.
  - One layer in both groups alone never collides; at least one A bit and one B bit must be set (they may be the same layer only if a second layer qualifies).
- Publish, at the frame boundary event:
  - If primed: oHitLayer <= accumulator, oHitCount <= count, oHitValid = 1 for exactly one cycle.
  - Always: accumulator and count are cleared, then primed <= 1.
  - The first boundary after reset only primes; it does not pulse oHitValid, so a partial frame is never reported.
- Simultaneous events: a collision on the boundary pixel itself counts toward the new frame, not the one being published.
- oHitLayer and oHitCount hold their values between publishes.
- Reset mid-frame: everything above is cleared immediately; the next boundary primes, and the one after that publishes.

Optional Feature:
- Macro LAYER_COMPOSITOR_HITCOUNT_EN.
  - Defined: the saturating 16-bit colliding-pixel counter exists and oHitCount is published as above.
  - Undefined: no counter logic; oHitCount is constant 0.
  - oHitLayer/oHitValid behaviour is identical either way.

Test Plan:
- Reset/latency: release reset, iActive=1, iPixel=0 → oR/oG/oB=BG_COLOR exactly 2 cycles after inputs; oPx/oPy equal the inputs delayed by 2; all hit outputs 0.
- Priority: iPixel=16'h0024, layer 2 colour 30'h3FF00000, layer 5 colour 30'h000FFC00 → output = layer 2 colour. Same pixels with iActive=0 → output 0.
- Collision: masks A=16'h0001, B=16'h7FE0; over one frame, 3 pixels with iPixel=16'h0021 → at the next boundary, oHitLayer=16'h0021, oHitCount=3, oHitValid high one cycle. Frame without overlap → oHitLayer=0.
- Priming: reset mid-frame, then collisions → first boundary gives no oHitValid; second boundary reports only the collisions of the intervening full frame.
- Mask latching and boundary pixel: change iGroupB mid-frame → takes effect only after the next boundary. A collision at (0,0) → counted in the following frame's report.
- Saturation (macro defined): 70000 colliding pixels in one frame → oHitCount=16'hFFFF. Macro undefined → oHitCount stays 0.
